wb_irq_ctrl: RTL
================

WB_IRQ_CTRL -- requirements
Module: wb_irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources (legal 1..31).
REQ-002 SHALL have parameter TAGSIZE, default 1, tag width of the attached wb_bus_t.
REQ-003 SHALL have port clk, input, 1, the only clock.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port src_i, input, N_SRC, raw interrupt lines (timer, gpio, ...); may be asynchronous to clk.
REQ-006 SHALL have port wb_bus, wb_bus_t slave modport, TAGSIZE, register access.
REQ-007 SHALL have port irq_o, output, 1, interrupt request to the core.
REQ-008 SHALL have port irq_id_o, output, 5, id of the highest-priority claimable source, where id = index+1 and 0 means none.

Function
REQ-009 SHALL pass each src_i bit through a 2-flop synchroniser; pulses shorter than one clk period are not guaranteed capture.
REQ-010 SHALL decode word offset adr[4:2]: 0 PENDING (R, W1C), 1 ENABLE (RW), 2 MODE (RW, 1=rising-edge, 0=level), 3 CLAIM (R=claim, W=complete), 4 INSERVICE (R).
REQ-011 SHALL make level-mode pending equal to the synchronised level; W1C has no effect on it.
REQ-012 SHALL set edge-mode pending on a synchronised 0->1 transition and hold it until W1C or claim; set wins over a simultaneous clear.
REQ-013 SHALL define claimable = pending & enable & ~inservice; lowest index has highest priority.
REQ-014 SHALL register irq_o = |claimable and irq_id_o one cycle after claimable changes; total src_i rise to irq_o = 4 clk edges.
REQ-015 SHALL, on a CLAIM read, return irq_id_o, set that source's inservice bit, and clear it if it is edge pending; if none is claimable, return 0 with no side effect.
REQ-016 SHALL, on a CLAIM write of an id, clear that inservice bit; id 0, id >N_SRC, or an id not in service SHALL be acked and ignored.
REQ-017 SHALL implement the bus handshake: ack registered one cycle after cyc&stb, high for exactly one cycle; a new request is ignored while ack is high; rdata is valid with ack.
REQ-018 SHALL ack and ignore writes to read-only registers; an unmapped offset (5..7) SHALL assert err instead of ack, with the same timing.
REQ-019 SHALL read bits >=N_SRC as 0 and ignore writes to them.
REQ-020 SHALL let a claim and a new edge on the same source in the same cycle leave pending set (re-trigger kept).
REQ-021 SHALL block a level source that is in service from re-asserting irq_o until its complete.
REQ-022 SHALL stop requests immediately after ENABLE is cleared; pending persists and irq_o drops one cycle later.

Reset
REQ-023 SHALL, while rst_i is high, force to 0 irq_o, irq_id_o, ack, err, rdata, sync flops, PENDING, ENABLE, MODE and INSERVICE.
REQ-024 SHALL abort an access in flight at reset with no ack; after release the first edge is detected only on a 0->1 seen after reset.

Structure
REQ-025 SHALL place the register offset constants, the MAX_SRC=31 constant and the id width constant in shared package irq_pkg.
REQ-026 SHALL use one sub-module, irq_src_cell, per source (synchroniser, edge detect, pending/inservice flops), generated N_SRC times; priority encoding and the bus interface live in wb_irq_ctrl.

Verification
REQ-027 SHALL verify: N_SRC=8, ENABLE=0xFF, MODE=0x01, src_i[0] pulse 1 cycle -> irq_o high 4 edges later, irq_id_o=1, CLAIM read=1, PENDING=0, INSERVICE=0x01, irq_o low.
REQ-028 SHALL verify: src_i[2] and src_i[5] rise together, level mode -> CLAIM reads 3 then 6; complete 3 with src_i[2] still high -> irq_id_o=3 again.
REQ-029 SHALL verify: CLAIM read with nothing pending -> 0, INSERVICE unchanged; complete of id 9 -> ack, no state change.
REQ-030 SHALL verify: read of offset 6 -> err for one cycle, no ack; write 0xFF to INSERVICE -> ack, value unchanged.
REQ-031 SHALL verify: edge on src_i[1] in the same cycle as W1C of PENDING bit 1 -> bit remains 1.
REQ-032 SHALL verify: rst_i asserted mid-access with src_i[3] held high, edge mode -> no ack, all registers 0, no pending until src_i[3] falls and rises again.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared constants and helpers for the Wishbone interrupt
//                controller (register map, source limits, id width).
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int MAX_SRC = 31;
    localparam int ID_W    = 5;

    // Word offsets decoded from adr[4:2]
    localparam logic [2:0] ADR_PENDING   = 3'd0;
    localparam logic [2:0] ADR_ENABLE    = 3'd1;
    localparam logic [2:0] ADR_MODE      = 3'd2;
    localparam logic [2:0] ADR_CLAIM     = 3'd3;
    localparam logic [2:0] ADR_INSERVICE = 3'd4;

    // Id (index+1) of the lowest set bit; 0 when no bit is set
    function automatic logic [ID_W-1:0] lowest_id(input logic [MAX_SRC-1:0] vec);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i + 1);
            end
        end
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bus_t.sv
`default_nettype none
// ============================================================================
//  Module      : wb_bus_t
//  Description : Classic Wishbone register-access bundle with a request tag
//                that the slave echoes back alongside ack/err.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_bus_t #(
    parameter int TAGSIZE = 1
);
    logic               cyc;
    logic               stb;
    logic               we;
    logic [31:0]        adr;
    logic [31:0]        dat_w;
    logic [31:0]        dat_r;
    logic               ack;
    logic               err;
    logic [TAGSIZE-1:0] tag;
    logic [TAGSIZE-1:0] tag_r;

    modport master (output cyc, stb, we, adr, dat_w, tag,
                    input  dat_r, ack, err, tag_r);
    modport slave  (input  cyc, stb, we, adr, dat_w, tag,
                    output dat_r, ack, err, tag_r);
endinterface
`default_nettype wire

// File: rtl/irq_src_cell.sv
`default_nettype none
// ============================================================================
//  Module      : irq_src_cell
//  Description : One interrupt source: 2-flop synchroniser, rising-edge
//                detect, edge-pending flop and in-service flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_src_cell (
    input  logic clk,
    input  logic rst_i,
    input  logic i_src,
    input  logic i_mode,
    input  logic i_w1c,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pending,
    output logic o_inservice
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [2:0] r_vld;
    logic       r_edge_pend;
    logic       r_inservice;
    logic       w_rise;

    // Synchroniser, one-cycle history, and a fill marker so that reset
    // values in the chain are never mistaken for a real 0->1 transition
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_vld   <= 3'b000;
        end else begin
            r_sync1 <= i_src;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_vld   <= {r_vld[1:0], 1'b1};
        end
    end

    assign w_rise = r_sync2 & ~r_prev & r_vld[2];

    // Edge pending: a new rise beats a simultaneous W1C or claim
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_edge_pend <= 1'b0;
        end else if (!i_mode) begin
            r_edge_pend <= 1'b0;
        end else begin
            r_edge_pend <= w_rise | (r_edge_pend & ~(i_w1c | i_claim));
        end
    end

    // In service from claim until complete
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_inservice <= 1'b0;
        end else begin
            r_inservice <= i_claim | (r_inservice & ~i_complete);
        end
    end

    // Level mode follows the delayed level so both modes share the same latency
    assign o_pending   = i_mode ? r_edge_pend : r_prev;
    assign o_inservice = r_inservice;

endmodule
`default_nettype wire

// File: rtl/wb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_irq_ctrl
//  Description : Wishbone-mapped interrupt controller with per-source
//                level/edge mode, enable, claim/complete and fixed priority
//                (lowest index wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC   = 8,
    parameter int TAGSIZE = 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] src_i,
    wb_bus_t.slave           wb_bus,
    output logic             irq_o,
    output logic [ID_W-1:0]  irq_id_o
);

    logic [N_SRC-1:0]   r_enable;
    logic [N_SRC-1:0]   r_mode;
    logic               r_ack;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic [TAGSIZE-1:0] r_tag;

    logic [N_SRC-1:0]   w_pending;
    logic [N_SRC-1:0]   w_inservice;
    logic [N_SRC-1:0]   w_claimable;
    logic [N_SRC-1:0]   w_w1c;
    logic [N_SRC-1:0]   w_claim;
    logic [N_SRC-1:0]   w_complete;
    logic [ID_W-1:0]    w_next_id;
    logic [31:0]        w_rdata;
    logic [2:0]         w_off;
    logic               w_req;
    logic               w_wr;
    logic               w_rd;
    logic               w_unmapped;
    logic               w_unused_adr;

    assign w_req        = wb_bus.cyc & wb_bus.stb & ~r_ack & ~r_err;
    assign w_off        = wb_bus.adr[4:2];
    assign w_unmapped   = (w_off > ADR_INSERVICE);
    assign w_wr         = w_req & wb_bus.we & ~w_unmapped;
    assign w_rd         = w_req & ~wb_bus.we & ~w_unmapped;
    assign w_unused_adr = ^{wb_bus.adr[31:5], wb_bus.adr[1:0]};

    assign w_claimable  = w_pending & r_enable & ~w_inservice;
    assign w_next_id    = lowest_id(MAX_SRC'(w_claimable));

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_src_cell u_cell (
            .clk        (clk),
            .rst_i      (rst_i),
            .i_src      (src_i[i]),
            .i_mode     (r_mode[i]),
            .i_w1c      (w_w1c[i]),
            .i_claim    (w_claim[i]),
            .i_complete (w_complete[i]),
            .o_pending  (w_pending[i]),
            .o_inservice(w_inservice[i])
        );
    end

    // Per-source strobes from the current bus access; a claim takes the
    // source that is claimable right now so back-to-back claims never repeat
    always_comb begin
        w_w1c      = '0;
        w_claim    = '0;
        w_complete = '0;
        if (w_wr && (w_off == ADR_PENDING)) begin
            w_w1c = wb_bus.dat_w[N_SRC-1:0];
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (w_rd && (w_off == ADR_CLAIM) && (w_next_id == ID_W'(i + 1))) begin
                w_claim[i] = 1'b1;
            end
            if (w_wr && (w_off == ADR_CLAIM) && (wb_bus.dat_w == 32'(i + 1)) && w_inservice[i]) begin
                w_complete[i] = 1'b1;
            end
        end
    end

    // Read data mux; bits at and above N_SRC read as zero
    always_comb begin
        w_rdata = '0;
        case (w_off)
            ADR_PENDING:   w_rdata[N_SRC-1:0] = w_pending;
            ADR_ENABLE:    w_rdata[N_SRC-1:0] = r_enable;
            ADR_MODE:      w_rdata[N_SRC-1:0] = r_mode;
            ADR_CLAIM:     w_rdata[ID_W-1:0]  = w_next_id;
            ADR_INSERVICE: w_rdata[N_SRC-1:0] = w_inservice;
            default:       w_rdata            = '0;
        endcase
    end

    // ENABLE and MODE registers
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_enable <= '0;
            r_mode   <= '0;
        end else begin
            if (w_wr && (w_off == ADR_ENABLE)) begin
                r_enable <= wb_bus.dat_w[N_SRC-1:0];
            end
            if (w_wr && (w_off == ADR_MODE)) begin
                r_mode <= wb_bus.dat_w[N_SRC-1:0];
            end
        end
    end

    // Single-cycle ack/err response with registered data and echoed tag
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_tag   <= '0;
        end else begin
            r_ack <= w_req & ~w_unmapped;
            r_err <= w_req & w_unmapped;
            if (w_req) begin
                r_rdata <= w_unmapped ? 32'd0 : w_rdata;
                r_tag   <= wb_bus.tag;
            end
        end
    end

    // Registered interrupt request and highest-priority id
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            irq_o    <= 1'b0;
            irq_id_o <= '0;
        end else begin
            irq_o    <= |w_claimable;
            irq_id_o <= w_next_id;
        end
    end

    assign wb_bus.ack   = r_ack;
    assign wb_bus.err   = r_err;
    assign wb_bus.dat_r = r_rdata;
    assign wb_bus.tag_r = r_tag;

endmodule
`default_nettype wire
